ca_life_engine: RTL and testbench
=================================

CA_LIFE_ENGINE -- requirements
Module: ca_life_engine

Interface
REQ-001 Parameter ROWS, default 8: grid rows, range 3..32.
REQ-002 Parameter COLS, default 8: grid columns, range 3..32.
REQ-003 Parameter WRAP, default 0: 0 treats off-grid neighbours as dead; 1 uses a toroidal grid.
REQ-004 Parameter BIRTH, default 9'b000001000: bit n set means a dead cell with n live neighbours is born.
REQ-005 Parameter SURVIVE, default 9'b000001100: bit n set means a live cell with n live neighbours survives.
REQ-006 Parameter GEN_W, default 16: generation counter width.
REQ-007 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-008 Port rst, input, 1: synchronous, active-high reset.
REQ-009 Port load, input, 1: when high, the grid is written from data_in.
REQ-010 Port data_in, input, ROWS*COLS: initial grid; cell (r,c) is bit r*COLS+c; 1 means live.
REQ-011 Port step, input, 1: single-cycle pulse requesting one generation while IDLE.
REQ-012 Port run, input, 1: level; requests free-running evolution.
REQ-013 Port period, input, 8: in RUN, one generation is computed every period+1 cycles.
REQ-014 Port data_out, output, ROWS*COLS: current grid register, same bit mapping as data_in.
REQ-015 Port gen_count, output, GEN_W: number of generations computed since the last load or reset.
REQ-016 Port state_o, output, 2: current state; IDLE=0, RUN=1, HALT=2.
REQ-017 Port stable, output, 1: the last computed generation equalled its predecessor.
REQ-018 Port extinct, output, 1: the grid holds no live cells while in RUN or HALT.

Function
REQ-019 Next-state rule: count live neighbours n (0..8) over the 8 surrounding cells; next = live ? SURVIVE[n] : BIRTH[n].
REQ-020 Neighbour indexing: with WRAP=1, row -1 maps to ROWS-1, row ROWS maps to 0, and columns map likewise; with WRAP=0, out-of-range neighbours count as 0.
REQ-021 Each generation updates every cell in one clock edge from the old grid (double-buffer semantics, no in-place partial updates).
REQ-022 Priority per cycle: rst > load > step/run.
REQ-023 Load: on the next edge, grid <= data_in; gen_count <= 0; stable <= 0; extinct <= 0; divider <= 0; state <= IDLE; this applies from any state.
REQ-024 IDLE with step=1 and run=0: exactly one generation on the next edge, and gen_count increments by 1.
REQ-025 IDLE with run=1: go to RUN on the next edge, divider <= 0, no generation on that edge; if step is also high, it is ignored.
REQ-026 RUN: divider counts 0..period; when divider==period, compute a generation and reset divider to 0, otherwise divider increments by 1; with period=0, one generation is computed per cycle.
REQ-027 RUN with run=0: return to IDLE on the next edge with no generation; grid and gen_count are held.
REQ-028 RUN, generation edge: if the computed next grid equals the current grid, set stable=1 and state <= HALT (the grid is written and gen_count increments).
REQ-029 RUN: if the current grid is all zero, set extinct=1 and state <= HALT on the next edge with no generation.
REQ-030 HALT: grid, gen_count and flags are held; step and run are ignored; only load or rst exits HALT, and both go to IDLE.
REQ-031 step is ignored in RUN and HALT; step in IDLE never sets stable or extinct and never causes HALT.
REQ-032 gen_count saturates at 2^GEN_W-1; it does not wrap.
REQ-033 data_out is the registered grid, so a generation is visible on the cycle after its edge.

Reset
REQ-034 rst=1 at an edge: grid <= 0; gen_count <= 0; stable <= 0; extinct <= 0; divider <= 0; state <= IDLE; this overrides load, step and run, including mid-RUN.

Verification
REQ-035 ROWS=COLS=8, WRAP=0: load a horizontal blinker at (3,2..4), then step twice -> vertical (2..4,3), then horizontal again; gen_count=2; stable=0.
REQ-036 Load a 2x2 block at (3..4,3..4), run=1, period=0 -> first generation unchanged, stable=1, state HALT, gen_count=1; a later step pulse leaves gen_count=1.
REQ-037 WRAP=1, 8x8: load a glider at (0,1),(1,2),(2,0),(2,1),(2,2), run with period=0 -> after 32 generations data_out equals the initial pattern.
REQ-038 Single live cell, run=1, period=3 -> generation at the 4th RUN cycle gives an empty grid, gen_count=1; the next cycle gives extinct=1 and HALT.
REQ-039 Glider in RUN, assert rst after 5 generations -> next cycle data_out=0, gen_count=0, IDLE; repeat with load instead -> grid=data_in, gen_count=0, IDLE.
REQ-040 WRAP=0, live cells at (0,0),(0,1),(1,0) -> one step gives (0,0),(0,1),(1,0),(1,1) with no toroidal births at row 7 or column 7.

Source files
------------

// File: rtl/ca_life_engine.sv
// ca_life_engine
//
// Purpose: cellular-automaton engine for "Life-like" rules on a ROWS x COLS
// grid. The grid is a single register that is rewritten from its own
// combinational next-state image, so every cell of a generation is computed
// from the same old grid. The engine can single-step while idle, or free-run
// with a programmable pacing divider. It halts by itself when a generation
// reproduces its predecessor or when the grid has no live cells.
//
// Ports:
//   clk        in   single clock, all state changes on its rising edge
//   rst        in   synchronous active-high reset (grid cleared, IDLE)
//   load       in   write grid from data_in, clear counters/flags, go IDLE
//   data_in    in   ROWS*COLS  initial grid, cell (r,c) at bit r*COLS+c
//   step       in   one-cycle pulse: compute one generation while IDLE
//   run        in   level: free-running evolution
//   period     in   8  RUN computes one generation every period+1 cycles
//   data_out   out  ROWS*COLS  current grid register
//   gen_count  out  GEN_W  generations since last load/reset, saturating
//   state_o    out  2  IDLE=0, RUN=1, HALT=2
//   stable     out  last generation equalled its predecessor
//   extinct    out  grid became empty while running
module ca_life_engine #(
    parameter int         ROWS    = 8,
    parameter int         COLS    = 8,
    parameter int         WRAP    = 0,
    parameter logic [8:0] BIRTH   = 9'b000001000,
    parameter logic [8:0] SURVIVE = 9'b000001100,
    parameter int         GEN_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] data_in,
    input  logic                 step,
    input  logic                 run,
    input  logic [7:0]           period,
    output logic [ROWS*COLS-1:0] data_out,
    output logic [GEN_W-1:0]     gen_count,
    output logic [1:0]           state_o,
    output logic                 stable,
    output logic                 extinct
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [CELLS-1:0] grid;
    logic [CELLS-1:0] next_grid;
    logic [GEN_W-1:0] gen_next;
    logic [7:0]       divider;
    logic [1:0]       state;
    logic             grid_empty;
    logic             grid_same;

    // Value of the neighbour at (r,c), which may lie one step off the grid.
    // Off-grid coordinates either fold back onto the torus or read as dead.
    function automatic logic cell_at(input logic [CELLS-1:0] g,
                                     input int r, input int c);
        int rr;
        int cc;
        rr = r;
        cc = c;
        if (WRAP != 0) begin
            if (rr < 0)          rr = rr + ROWS;
            else if (rr >= ROWS) rr = rr - ROWS;
            if (cc < 0)          cc = cc + COLS;
            else if (cc >= COLS) cc = cc - COLS;
            return g[IDX_W'(rr * COLS + cc)];
        end
        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS)
            return 1'b0;
        return g[IDX_W'(rr * COLS + cc)];
    endfunction

    function automatic logic [3:0] live_neighbours(input logic [CELLS-1:0] g,
                                                   input int r, input int c);
        logic [3:0] n;
        n = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0)
                    n = n + 4'(cell_at(g, r + dr, c + dc));
            end
        end
        return n;
    endfunction

    // Whole-grid next generation, evaluated purely from the current register.
    always_comb begin
        next_grid = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                logic [3:0] n;
                n = live_neighbours(grid, r, c);
                next_grid[r * COLS + c] = grid[r * COLS + c] ? SURVIVE[n] : BIRTH[n];
            end
        end
    end

    assign grid_empty = (grid == '0);
    assign grid_same  = (next_grid == grid);

    // Generation counter sticks at all-ones instead of wrapping.
    assign gen_next = (gen_count == '1) ? gen_count : gen_count + GEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            grid      <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
            extinct   <= 1'b0;
            divider   <= '0;
            state     <= ST_IDLE;
        end else if (load) begin
            grid      <= data_in;
            gen_count <= '0;
            stable    <= 1'b0;
            extinct   <= 1'b0;
            divider   <= '0;
            state     <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // run wins over a simultaneous step; entering RUN is not
                    // itself a generation edge.
                    if (run) begin
                        state   <= ST_RUN;
                        divider <= '0;
                    end else if (step) begin
                        grid      <= next_grid;
                        gen_count <= gen_next;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state <= ST_IDLE;
                    end else if (grid_empty) begin
                        extinct <= 1'b1;
                        state   <= ST_HALT;
                    end else if (divider == period) begin
                        grid      <= next_grid;
                        gen_count <= gen_next;
                        divider   <= '0;
                        if (grid_same) begin
                            stable <= 1'b1;
                            state  <= ST_HALT;
                        end
                    end else begin
                        divider <= divider + 8'd1;
                    end
                end
                ST_HALT: begin
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign data_out = grid;
    assign state_o  = state;

endmodule

// File: tb/tb_ca_life_engine.sv
// tb_ca_life_engine
//
// Purpose: self-checking bench for ca_life_engine. Two engines share one
// stimulus stream: dut0 (8x8, bounded grid, 16-bit counter) and dut1
// (8x8, toroidal grid, 4-bit counter so saturation is reachable). A
// behavioural reference queues the expected outputs of every clock edge;
// a negedge monitor pops and compares them. Directed scenarios add
// hand-derived constant checks on top.
module tb_ca_life_engine;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [63:0] BLINK_H   = 64'h00000000_1C000000;
    localparam logic [63:0] BLINK_V   = 64'h00000008_08080000;
    localparam logic [63:0] BLOCK     = 64'h00000018_18000000;
    localparam logic [63:0] GLIDER    = 64'h00000000_00070402;
    localparam logic [63:0] SINGLE    = 64'h00000010_00000000;
    localparam logic [63:0] CORNER    = 64'h00000000_00000103;
    localparam logic [63:0] CORNER_NX = 64'h00000000_00000303;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [63:0] din = '0;
    logic        step = 1'b0;
    logic        run = 1'b0;
    logic [7:0]  period = 8'd0;

    logic [63:0] out0, out1;
    logic [15:0] gen0;
    logic [3:0]  gen1;
    logic [1:0]  st0, st1;
    logic        stab0, stab1, ext0, ext1;

    int errors = 0;
    int checks = 0;

    ca_life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(16)) dut0 (
        .clk(clk), .rst(rst), .load(load), .data_in(din), .step(step),
        .run(run), .period(period), .data_out(out0), .gen_count(gen0),
        .state_o(st0), .stable(stab0), .extinct(ext0)
    );

    ca_life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(4)) dut1 (
        .clk(clk), .rst(rst), .load(load), .data_in(din), .step(step),
        .run(run), .period(period), .data_out(out1), .gen_count(gen1),
        .state_o(st1), .stable(stab1), .extinct(ext1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] life_ref(input logic [63:0] g, input bit wrap);
        logic [63:0] nx;
        nx = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int cnt;
                logic [5:0] me;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        logic [5:0] idx;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end
                        idx = 6'(rr * 8 + cc);
                        if (!(dr == 0 && dc == 0) &&
                            (wrap || (rr >= 0 && rr <= 7 && cc >= 0 && cc <= 7)) &&
                            g[idx])
                            cnt++;
                    end
                end
                me = 6'(r * 8 + c);
                nx[me] = g[me] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return nx;
    endfunction

    function automatic logic [63:0] pack(input logic [15:0] gen, input logic [1:0] st,
                                         input logic stab, input logic ext);
        return 64'({gen, st, stab, ext});
    endfunction

    logic [63:0]  mg   [2] = '{64'h0, 64'h0};
    int unsigned  mgen [2] = '{0, 0};
    int unsigned  gmax [2] = '{65535, 15};
    logic [1:0]   mst  [2] = '{S_IDLE, S_IDLE};
    logic         mstab[2] = '{1'b0, 1'b0};
    logic         mext [2] = '{1'b0, 1'b0};
    int unsigned  mdiv [2] = '{0, 0};

    typedef struct {
        logic [63:0] g0, s0, g1, s1;
        logic [31:0] edge_no;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic model_edge();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            logic [63:0] nx;
            nx = life_ref(mg[i], i == 1);
            if (rst) begin
                mg[i] = '0; mgen[i] = 0; mstab[i] = 0; mext[i] = 0; mdiv[i] = 0; mst[i] = S_IDLE;
            end else if (load) begin
                mg[i] = din; mgen[i] = 0; mstab[i] = 0; mext[i] = 0; mdiv[i] = 0; mst[i] = S_IDLE;
            end else if (mst[i] == S_IDLE) begin
                if (run) begin
                    mst[i] = S_RUN; mdiv[i] = 0;
                end else if (step) begin
                    mg[i] = nx;
                    if (mgen[i] < gmax[i]) mgen[i]++;
                end
            end else if (mst[i] == S_RUN) begin
                if (!run) mst[i] = S_IDLE;
                else if (mg[i] == 64'h0) begin
                    mext[i] = 1; mst[i] = S_HALT;
                end else if (mdiv[i] == 32'(period)) begin
                    if (nx == mg[i]) begin
                        mstab[i] = 1; mst[i] = S_HALT;
                    end
                    mg[i] = nx;
                    if (mgen[i] < gmax[i]) mgen[i]++;
                    mdiv[i] = 0;
                end else mdiv[i]++;
            end
        end
        e.g0 = mg[0];
        e.s0 = pack(16'(mgen[0]), mst[0], mstab[0], mext[0]);
        e.g1 = mg[1];
        e.s1 = pack(16'(mgen[1]), mst[1], mstab[1], mext[1]);
        e.edge_no = edge_cnt + 1;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].edge_no == edge_cnt) begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_grid0", out0, e.g0);
            chk("sb_stat0", pack(gen0, st0, stab0, ext0), e.s0);
            chk("sb_grid1", out1, e.g1);
            chk("sb_stat1", pack(16'(gen1), st1, stab1, ext1), e.s1);
        end
    end

    // One clock edge with the inputs currently driven; returns at the
    // following negedge so outputs of that edge are settled.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [63:0] p);
        load = 1'b1;
        din  = p;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_grid", out0, 64'h0);
        chk("rst_gen", 64'(gen0), 64'd0);
        chk("rst_state", 64'(st0), 64'(S_IDLE));
        chk("rst_flags", 64'({stab0, ext0}), 64'd0);

        // blinker oscillation by single steps
        do_load(BLINK_H);
        step = 1'b1; tick(); step = 1'b0;
        chk("blink_v", out0, BLINK_V);
        chk("blink_gen1", 64'(gen0), 64'd1);
        step = 1'b1; tick(); step = 1'b0;
        chk("blink_h", out0, BLINK_H);
        chk("blink_gen2", 64'(gen0), 64'd2);
        chk("blink_stable", 64'(stab0), 64'd0);

        // still life halts on its first RUN generation
        do_load(BLOCK);
        run = 1'b1; step = 1'b1; period = 8'd0;
        tick();
        step = 1'b0;
        chk("block_enter_st", 64'(st0), 64'(S_RUN));
        chk("block_enter_gen", 64'(gen0), 64'd0);
        tick();
        chk("block_grid", out0, BLOCK);
        chk("block_stable", 64'(stab0), 64'd1);
        chk("block_halt", 64'(st0), 64'(S_HALT));
        chk("block_gen", 64'(gen0), 64'd1);
        run = 1'b0; step = 1'b1; tick(); step = 1'b0;
        chk("block_step_gen", 64'(gen0), 64'd1);
        chk("block_step_st", 64'(st0), 64'(S_HALT));

        // toroidal glider returns home after 32 generations
        do_load(GLIDER);
        run = 1'b1;
        tick();
        repeat (32) tick();
        chk("glider_wrap", out1, GLIDER);
        chk("glider_gen_sat", 64'(gen1), 64'd15);
        run = 1'b0;
        tick();
        chk("glider_idle", 64'(st1), 64'(S_IDLE));
        chk("glider_hold", out1, GLIDER);

        // lone cell dies on the 4th RUN cycle, then extinction halts
        do_load(SINGLE);
        period = 8'd3; run = 1'b1;
        tick();
        repeat (3) tick();
        chk("single_wait_gen", 64'(gen0), 64'd0);
        chk("single_wait_grid", out0, SINGLE);
        tick();
        chk("single_dead", out0, 64'h0);
        chk("single_gen", 64'(gen0), 64'd1);
        chk("single_run", 64'(st0), 64'(S_RUN));
        chk("single_ext0", 64'(ext0), 64'd0);
        tick();
        chk("single_ext", 64'(ext0), 64'd1);
        chk("single_halt", 64'(st0), 64'(S_HALT));
        run = 1'b0;

        // reset and load abort a running glider
        do_load(GLIDER);
        period = 8'd0; run = 1'b1;
        tick();
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_rst_grid", out0, 64'h0);
        chk("abort_rst_gen", 64'(gen0), 64'd0);
        chk("abort_rst_st", 64'(st0), 64'(S_IDLE));
        do_load(GLIDER);
        tick();
        repeat (5) tick();
        do_load(GLIDER);
        chk("abort_ld_grid", out0, GLIDER);
        chk("abort_ld_gen", 64'(gen0), 64'd0);
        chk("abort_ld_st", 64'(st0), 64'(S_IDLE));
        run = 1'b0;

        // corner: no births across the bounded edge
        do_load(CORNER);
        step = 1'b1; tick(); step = 1'b0;
        chk("corner_next", out0, CORNER_NX);

        // random traffic, checked only through the scoreboard
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_load({$urandom, $urandom} & {$urandom, $urandom});
            end else begin
                rst    = ($urandom_range(0, 99) == 0);
                step   = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 9) == 0) run = ~run;
                if ($urandom_range(0, 19) == 0) period = 8'($urandom_range(0, 3));
                tick();
                rst = 1'b0; step = 1'b0;
            end
        end

        #2;
        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
